// File: rtl/acs_ctrl.sv
// ============================================================================
//  Module   : acs_ctrl
//  Brief    : Viterbi ACS frame controller - path-metric regs, survivor writes,
//             normalization and traceback handshake.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module acs_ctrl #(
    parameter int         FRAME_LEN = 64,
    parameter logic [7:0] NORM_THR  = 8'd128,
    parameter logic [7:0] PM_INIT   = 8'd63
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       sym_valid_i,
    output logic       sym_ready_o,
    output logic [7:0] pm_s0_o,
    output logic [7:0] pm_s1_o,
    output logic [7:0] pm_s2_o,
    output logic [7:0] pm_s3_o,
    input  logic [7:0] acs_pm_s0_i,
    input  logic [7:0] acs_pm_s1_i,
    input  logic [7:0] acs_pm_s2_i,
    input  logic [7:0] acs_pm_s3_i,
    input  logic [3:0] acs_dec_i,
    output logic       dec_we_o,
    output logic [7:0] dec_addr_o,
    output logic [3:0] dec_bits_o,
    output logic       norm_o,
    output logic       tb_start_o,
    output logic [1:0] tb_state_o,
    input  logic       tb_done_i,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_TB_REQ  = 2'd2,
        S_TB_WAIT = 2'd3
    } state_t;

    localparam logic [7:0] C_LAST = 8'(FRAME_LEN - 1);

    state_t     r_state;
    logic [7:0] r_cnt;

    // Index of the smallest of four metrics; ties go to the lower index.
    function automatic logic [1:0] f_argmin(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] d);
        logic [7:0] m01;
        logic [7:0] m23;
        logic [1:0] i01;
        logic [1:0] i23;
        i01 = (b < a) ? 2'd1 : 2'd0;
        m01 = (b < a) ? b : a;
        i23 = (d < c) ? 2'd3 : 2'd2;
        m23 = (d < c) ? d : c;
        return (m23 < m01) ? i23 : i01;
    endfunction

    logic       w_accept;
    logic [1:0] w_min_idx;
    logic [7:0] w_min_val;
    logic       w_norm;
    logic [7:0] w_sub;

    // Subtracting a common constant preserves the argmin, so one comparator
    // tree serves both the normalization test and the traceback start state.
    always_comb begin
        w_accept  = (r_state == S_RUN) && sym_valid_i && sym_ready_o;
        w_min_idx = f_argmin(acs_pm_s0_i, acs_pm_s1_i, acs_pm_s2_i, acs_pm_s3_i);
        case (w_min_idx)
            2'd0:    w_min_val = acs_pm_s0_i;
            2'd1:    w_min_val = acs_pm_s1_i;
            2'd2:    w_min_val = acs_pm_s2_i;
            default: w_min_val = acs_pm_s3_i;
        endcase
        w_norm = (w_min_val >= NORM_THR);
        w_sub  = w_norm ? NORM_THR : 8'd0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            pm_s0_o     <= 8'd0;
            pm_s1_o     <= 8'd0;
            pm_s2_o     <= 8'd0;
            pm_s3_o     <= 8'd0;
            sym_ready_o <= 1'b0;
            dec_we_o    <= 1'b0;
            dec_addr_o  <= 8'd0;
            dec_bits_o  <= 4'd0;
            norm_o      <= 1'b0;
            tb_start_o  <= 1'b0;
            tb_state_o  <= 2'd0;
            busy_o      <= 1'b0;
        end else begin
            dec_we_o   <= 1'b0;
            norm_o     <= 1'b0;
            tb_start_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        pm_s0_o     <= 8'd0;
                        pm_s1_o     <= PM_INIT;
                        pm_s2_o     <= PM_INIT;
                        pm_s3_o     <= PM_INIT;
                        r_cnt       <= 8'd0;
                        sym_ready_o <= 1'b1;
                        busy_o      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        pm_s0_o    <= acs_pm_s0_i - w_sub;
                        pm_s1_o    <= acs_pm_s1_i - w_sub;
                        pm_s2_o    <= acs_pm_s2_i - w_sub;
                        pm_s3_o    <= acs_pm_s3_i - w_sub;
                        norm_o     <= w_norm;
                        dec_we_o   <= 1'b1;
                        dec_addr_o <= r_cnt;
                        dec_bits_o <= acs_dec_i;
                        if (r_cnt == C_LAST) begin
                            r_cnt       <= 8'd0;
                            sym_ready_o <= 1'b0;
                            tb_start_o  <= 1'b1;
                            tb_state_o  <= w_min_idx;
                            r_state     <= S_TB_REQ;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_TB_REQ: begin
                    r_state <= S_TB_WAIT;
                end
                default: begin
                    if (tb_done_i) begin
                        busy_o  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_acs_ctrl.sv
// ============================================================================
//  Module   : tb_acs_ctrl
//  Brief    : Directed self-checking bench for acs_ctrl (FRAME_LEN = 4).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_acs_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       sym_valid_i = 1'b0;
    logic       sym_ready_o;
    logic [7:0] pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o;
    logic [7:0] acs_pm_s0_i = 8'd0, acs_pm_s1_i = 8'd0, acs_pm_s2_i = 8'd0, acs_pm_s3_i = 8'd0;
    logic [3:0] acs_dec_i = 4'd0;
    logic       dec_we_o;
    logic [7:0] dec_addr_o;
    logic [3:0] dec_bits_o;
    logic       norm_o;
    logic       tb_start_o;
    logic [1:0] tb_state_o;
    logic       tb_done_i = 1'b0;
    logic       busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_we    = 0;
    int n_tbs   = 0;
    logic [3:0] addr_seen = 4'd0;

    acs_ctrl #(.FRAME_LEN(4), .NORM_THR(8'd128), .PM_INIT(8'd63)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .sym_valid_i(sym_valid_i),
        .sym_ready_o(sym_ready_o),
        .pm_s0_o(pm_s0_o), .pm_s1_o(pm_s1_o), .pm_s2_o(pm_s2_o), .pm_s3_o(pm_s3_o),
        .acs_pm_s0_i(acs_pm_s0_i), .acs_pm_s1_i(acs_pm_s1_i),
        .acs_pm_s2_i(acs_pm_s2_i), .acs_pm_s3_i(acs_pm_s3_i),
        .acs_dec_i(acs_dec_i), .dec_we_o(dec_we_o), .dec_addr_o(dec_addr_o),
        .dec_bits_o(dec_bits_o), .norm_o(norm_o), .tb_start_o(tb_start_o),
        .tb_state_o(tb_state_o), .tb_done_i(tb_done_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Counts survivor writes and traceback pulses seen at each rising edge.
    always @(posedge clk_i) begin
        if (dec_we_o) begin
            n_we <= n_we + 1;
            if (dec_addr_o < 8'd4) addr_seen[dec_addr_o[1:0]] <= 1'b1;
        end
        if (tb_start_o) n_tbs <= n_tbs + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d, input logic [3:0] dec);
        sym_valid_i = v;
        acs_pm_s0_i = a; acs_pm_s1_i = b; acs_pm_s2_i = c; acs_pm_s3_i = d;
        acs_dec_i   = dec;
    endtask

    function automatic logic [31:0] pm();
        return {pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o};
    endfunction

    function automatic logic [31:0] outs();
        return {16'd0, sym_ready_o, dec_we_o, norm_o, tb_start_o, busy_o, tb_state_o,
                dec_bits_o, 5'd0} | {dec_addr_o, 24'd0} | pm();
    endfunction

    initial begin
        #2;
        chk("reset_outs", outs(), 32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        chk("idle_ready", {30'd0, sym_ready_o, busy_o}, 32'd0);

        // Frame 1: init
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("init_ctl", {30'd0, busy_o, sym_ready_o}, 32'h3);
        chk("init_pm", pm(), {8'd0, 8'd63, 8'd63, 8'd63});

        // accept 0
        drive(1'b1, 8'd0, 8'd20, 8'd0, 8'd20, 4'b0000);
        tick();
        chk("step_pm", pm(), {8'd0, 8'd20, 8'd0, 8'd20});
        chk("step_wr", {dec_we_o, dec_addr_o, dec_bits_o, norm_o}, {1'b1, 8'd0, 4'b0000, 1'b0});
        drive(1'b0, 8'd99, 8'd99, 8'd99, 8'd99, 4'b1111);
        tick();
        chk("stall_hold", {dec_we_o, dec_addr_o, dec_bits_o}, {1'b0, 8'd0, 4'b0000});
        chk("stall_pm", pm(), {8'd0, 8'd20, 8'd0, 8'd20});

        // accept 1: normalized
        drive(1'b1, 8'd130, 8'd140, 8'd200, 8'd128, 4'b1010);
        tick();
        chk("norm_pm", pm(), {8'd2, 8'd12, 8'd72, 8'd0});
        chk("norm_wr", {norm_o, dec_we_o, dec_addr_o, dec_bits_o}, {1'b1, 1'b1, 8'd1, 4'b1010});
        drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000);
        tick();
        chk("norm_pulse_end", {31'd0, norm_o}, 32'd0);

        // accept 2: just below threshold
        drive(1'b1, 8'd127, 8'd200, 8'd200, 8'd200, 4'b0101);
        tick();
        chk("nonorm_pm", pm(), {8'd127, 8'd200, 8'd200, 8'd200});
        chk("nonorm_wr", {norm_o, dec_addr_o, dec_bits_o}, {1'b0, 8'd2, 4'b0101});
        drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000);
        tick();

        // accept 3: last step of frame, tie between S1 and S2
        drive(1'b1, 8'd9, 8'd3, 8'd3, 8'd7, 4'b0011);
        tick();
        chk("last_pm", pm(), {8'd9, 8'd3, 8'd3, 8'd7});
        chk("last_wr", {dec_we_o, dec_addr_o}, {1'b1, 8'd3});
        chk("tb_req", {tb_start_o, tb_state_o, sym_ready_o, busy_o}, {1'b1, 2'd1, 1'b0, 1'b1});
        drive(1'b1, 8'd1, 8'd1, 8'd1, 8'd1, 4'b1111);
        tick();
        chk("tb_pulse_end", {tb_start_o, dec_we_o, tb_state_o}, {1'b0, 1'b0, 2'd1});

        // Traceback wait; start_i and sym_valid_i must be ignored
        for (int i = 0; i < 10; i++) begin
            start_i = (i == 4);
            tick();
            chk("tb_wait", {sym_ready_o, busy_o, dec_we_o}, {1'b0, 1'b1, 1'b0});
        end
        drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000);
        tb_done_i = 1'b1;
        start_i   = 1'b1;
        tick();
        tb_done_i = 1'b0;
        start_i   = 1'b0;
        chk("tb_done_idle", {busy_o, sym_ready_o, tb_state_o}, {1'b0, 1'b0, 2'd1});
        tick();
        chk("still_idle", {30'd0, busy_o, sym_ready_o}, 32'd0);
        chk("frame_writes", n_we, 32'd4);
        chk("frame_addrs", {28'd0, addr_seen}, 32'hF);
        chk("frame_tbs", n_tbs, 32'd1);

        // Frame 2: reset after two accepts
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        drive(1'b1, 8'd5, 8'd6, 8'd7, 8'd8, 4'b1001);
        tick();
        tick();
        chk("f2_addr", {dec_we_o, dec_addr_o}, {1'b1, 8'd1});
        rst_i = 1'b1;
        #1;
        chk("async_reset", outs(), 32'd0);
        tick();
        rst_i = 1'b0;
        n_we = 0;
        for (int i = 0; i < 6; i++) begin
            sym_valid_i = i[0];
            tick();
        end
        sym_valid_i = 1'b0;
        tick();
        chk("post_reset_nowr", n_we, 32'd0);
        chk("post_reset_idle", outs(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
